// File: rtl/xy_scan_pkg.sv
// xy_scan_pkg: shared types and width helpers for xy_scan_engine
package xy_scan_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  typedef struct packed {
    logic sof;
    logic eof;
    logic sol;
    logic eol;
  } marker_t;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/scan_axis_counter.sv
// scan_axis_counter: one scan axis; load returns to origin, steps up to limit or down to 0 and
// then holds, with last flagging the end of travel in the current direction.
module scan_axis_counter #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic         dir,
  input  logic [N-1:0] limit,
  output logic [N-1:0] q,
  output logic         last
);
  assign last = dir ? q == '0 : q == limit;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (load) q <= '0;
    else if (en && !last) q <= dir ? q - 1'b1 : q + 1'b1;
endmodule

// File: rtl/xy_scan_engine.sv
// xy_scan_engine: programmable raster scan generator with valid/ready output and frame markers.
// Define XY_SCAN_SERPENTINE_EN to honour cfg_serp (odd rows scanned right to left).
module xy_scan_engine
  import xy_scan_pkg::*;
#(
  parameter int MAX_WIDTH  = 640,
  parameter int MAX_HEIGHT = 480,
  parameter int FRAME_BITS = 8,
  localparam int XW = cw(MAX_WIDTH),
  localparam int YW = cw(MAX_HEIGHT)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic [XW:0]           cfg_width,
  input  logic [YW:0]           cfg_height,
  input  logic                  cfg_serp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XW-1:0]         x,
  output logic [YW-1:0]         y,
  output logic                  sof,
  output logic                  eof,
  output logic                  sol,
  output logic                  eol,
  output logic                  busy,
  output logic                  cfg_err,
  output logic [FRAME_BITS-1:0] frame_count
);
  localparam logic [XW:0] WMAX = (XW+1)'(MAX_WIDTH);
  localparam logic [YW:0] HMAX = (YW+1)'(MAX_HEIGHT);
  state_t        state;
  marker_t       m;
  logic [XW-1:0] w_m1;
  logic [YW-1:0] h_m1;
  logic loop_q, serp_q, stop_pend, row_rev, x_last, y_last;
  logic accept, frame_end, cfg_ok, start_go, cont;
  assign cfg_ok    = cfg_width != '0 && cfg_width <= WMAX && cfg_height != '0 && cfg_height <= HMAX;
  assign start_go  = state == IDLE && start && cfg_ok;
  assign accept    = out_valid && out_ready;
  assign row_rev   = serp_q && y[0];
  assign m.sol     = out_valid && (row_rev ? x == w_m1 : x == '0);
  assign m.eol     = out_valid && x_last;
  assign m.sof     = m.sol && y == '0;
  assign m.eof     = m.eol && y_last;
  assign {sof, eof, sol, eol} = m;
  assign frame_end = accept && m.eof;
  // a stop arriving with the final beat still ends the scan after this frame
  assign cont      = loop_q && !stop_pend && !stop;
  assign busy      = state != IDLE;
  scan_axis_counter #(.N(XW)) u_x (
    .clock(clock), .reset_n(reset_n),
    .load(start_go || frame_end || (accept && x_last && !serp_q)),
    .en(accept), .dir(row_rev), .limit(w_m1), .q(x), .last(x_last)
  );
  scan_axis_counter #(.N(YW)) u_y (
    .clock(clock), .reset_n(reset_n),
    .load(start_go || frame_end),
    .en(accept && x_last), .dir(1'b0), .limit(h_m1), .q(y), .last(y_last)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      cfg_err     <= 1'b0;
      frame_count <= '0;
      stop_pend   <= 1'b0;
      loop_q      <= 1'b0;
      w_m1        <= '0;
      h_m1        <= '0;
    end else begin
      cfg_err <= state == IDLE && start && !cfg_ok;
      if (start_go) begin
        state     <= RUN;
        out_valid <= 1'b1;
        w_m1      <= XW'(cfg_width - 1'b1);
        h_m1      <= YW'(cfg_height - 1'b1);
        loop_q    <= loop;
        stop_pend <= 1'b0;
      end else if (state == RUN) begin
        if (stop) stop_pend <= 1'b1;
        if (frame_end) begin
          frame_count <= frame_count + 1'b1;
          if (!cont) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            stop_pend <= 1'b0;
          end
        end
      end
    end
`ifdef XY_SCAN_SERPENTINE_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) serp_q <= 1'b0;
    else if (start_go) serp_q <= cfg_serp;
`else
  logic unused_serp;
  assign serp_q      = 1'b0;
  assign unused_serp = cfg_serp;
`endif
endmodule
